// File: rtl/spy_pkg.sv
// -----------------------------------------------------------------------------
// spy_pkg
// Shared definitions for the spy delay-path launch/capture controller.
//   state_t          : controller FSM states
//   DEF_*            : default widths and timing used by spy_path_sampler
//   counterWidth()   : bits needed for a down-counter that is loaded with maxVal
// -----------------------------------------------------------------------------
package spy_pkg;

  // One measurement trial walks LAUNCH -> WAIT -> CAPTURE -> COMPARE -> SETTLE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    COMPARE = 3'd4,
    SETTLE  = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int DEF_CNT_W         = 16;
  localparam int DEF_WAIT_W        = 8;
  localparam int DEF_SETTLE_CYCLES = 4;

  // Width of a counter that must hold values 0..maxVal, never narrower than 1.
  function automatic int counterWidth(input int maxVal);
    if (maxVal < 2) begin
      return 1;
    end
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/spy_path_sampler.sv
// -----------------------------------------------------------------------------
// spy_path_sampler
// Launch/capture controller wrapped around a chained spy delay path. Each trial
// toggles the registered chain input, samples the chain output wait_cycles+1
// clock periods later and counts samples that disagree with the settled value.
// A non-zero err_count means the chain delay exceeds the capture window.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request a batch (only honoured in IDLE)
//   num_trials   in   trials per batch, latched on accept
//   wait_cycles  in   capture window, latched on accept
//   path_input   out  registered launch signal driving the chain input
//   path_result  in   chain output (no timing relation to clk by design)
//   busy         out  high from accept through the DONE cycle
//   done         out  one-cycle pulse at the end of a batch
//   err_count    out  mismatches of the last batch, held until next accept
//   last_sample  out  most recently captured path_result
// -----------------------------------------------------------------------------
module spy_path_sampler
  import spy_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int WAIT_W        = DEF_WAIT_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter bit INVERTING     = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_trials,
  input  logic [WAIT_W-1:0] wait_cycles,
  output logic              path_input,
  input  logic              path_result,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic              last_sample
);

  localparam int SET_W = counterWidth(SETTLE_CYCLES);

  state_t            r_state;
  state_t            w_next_state;

  logic [CNT_W-1:0]  r_num_trials;
  logic [CNT_W-1:0]  r_trial;
  logic [CNT_W-1:0]  r_err_count;
  logic [WAIT_W-1:0] r_wait_cycles;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [SET_W-1:0]  r_settle_cnt;
  logic              r_path_input;
  logic              r_expected;
  logic              r_last_sample;

  logic              w_accept;
  logic              w_last_trial;

  // The trial counter is bumped in COMPARE, so the batch ends when the
  // incremented value would reach the latched trial count.
  assign w_accept     = (r_state == IDLE) && start;
  assign w_last_trial = ((r_trial + CNT_W'(1)) == r_num_trials);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and state-derived outputs. The WAIT counter is loaded
  // with a non-zero value whenever WAIT is entered, so leaving on a count of
  // one gives exactly wait_cycles cycles in WAIT.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = (num_trials == '0) ? DONE : LAUNCH;
        end
      end
      LAUNCH: begin
        w_next_state = (r_wait_cycles == '0) ? CAPTURE : WAIT;
      end
      WAIT: begin
        if (r_wait_cnt <= WAIT_W'(1)) begin
          w_next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        w_next_state = COMPARE;
      end
      COMPARE: begin
        w_next_state = w_last_trial ? DONE : SETTLE;
      end
      SETTLE: begin
        if (r_settle_cnt <= SET_W'(1)) begin
          w_next_state = LAUNCH;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_next_state = IDLE;
      end
    endcase
  end

  // Batch configuration and result counters. Inputs are only sampled on
  // accept, so later changes of num_trials or wait_cycles are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_trials  <= '0;
      r_wait_cycles <= '0;
      r_trial       <= '0;
      r_err_count   <= '0;
    end else begin
      if (w_accept) begin
        r_num_trials  <= num_trials;
        r_wait_cycles <= wait_cycles;
        r_trial       <= '0;
        r_err_count   <= '0;
      end else if (r_state == COMPARE) begin
        r_trial <= r_trial + CNT_W'(1);
        if (r_last_sample != r_expected) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
      end
    end
  end

  // Launch and capture registers. path_input toggles on the edge leaving
  // LAUNCH and is otherwise held, so it alternates polarity every trial and
  // persists across batches. The expected settled value follows the new
  // launch level through the chain parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_path_input  <= 1'b0;
      r_expected    <= 1'b0;
      r_last_sample <= 1'b0;
    end else begin
      if (r_state == LAUNCH) begin
        r_path_input <= ~r_path_input;
        r_expected   <= (~r_path_input) ^ INVERTING;
      end
      if (r_state == CAPTURE) begin
        r_last_sample <= path_result;
      end
    end
  end

  // Window and settle down-counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt   <= '0;
      r_settle_cnt <= '0;
    end else begin
      case (r_state)
        LAUNCH:  r_wait_cnt   <= r_wait_cycles;
        WAIT:    r_wait_cnt   <= r_wait_cnt - WAIT_W'(1);
        COMPARE: r_settle_cnt <= SET_W'(SETTLE_CYCLES);
        SETTLE:  r_settle_cnt <= r_settle_cnt - SET_W'(1);
        default: begin
        end
      endcase
    end
  end

  assign path_input  = r_path_input;
  assign err_count   = r_err_count;
  assign last_sample = r_last_sample;

endmodule

// File: tb/tb_spy_path_sampler.sv
// -----------------------------------------------------------------------------
// tb_spy_path_sampler
// Directed bench for spy_path_sampler. Two instances run in lockstep from the
// same stimulus: dut0 (non-inverting parity) and dut1 (inverting parity).
// Chain models: a 2.5-clock non-inverting delay and a 1.5-clock inverting
// delay. dut0 is fed from the 2.5-clock model unless modelSel selects the
// inverting one; dut1 always sees the inverting model.
// -----------------------------------------------------------------------------
module tb_spy_path_sampler;

  localparam int CLK_HALF = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] numTrials;
  logic [7:0]  waitCycles;
  logic        modelSel;

  logic        pathIn0, pathRes0, busy0, done0, last0;
  logic [15:0] err0;
  logic        pathIn1, pathRes1, busy1, done1, last1;
  logic [15:0] err1;

  logic        delayed0  = 1'b0;
  logic        inverted0 = 1'b1;
  logic        inverted1 = 1'b1;
  logic        tmpD0, tmpI0, tmpI1;

  int          checkCount = 0;
  int          errorCount = 0;

  always #CLK_HALF clk = ~clk;

  spy_path_sampler #(
    .CNT_W(16), .WAIT_W(8), .SETTLE_CYCLES(4), .INVERTING(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_trials(numTrials),
    .wait_cycles(waitCycles), .path_input(pathIn0), .path_result(pathRes0),
    .busy(busy0), .done(done0), .err_count(err0), .last_sample(last0)
  );

  spy_path_sampler #(
    .CNT_W(16), .WAIT_W(8), .SETTLE_CYCLES(4), .INVERTING(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_trials(numTrials),
    .wait_cycles(waitCycles), .path_input(pathIn1), .path_result(pathRes1),
    .busy(busy1), .done(done1), .err_count(err1), .last_sample(last1)
  );

  // Chain models: 25 ns = 2.5 clocks, 15 ns = 1.5 clocks. Launches are many
  // clocks apart, so each transition finishes before the next one starts.
  always @(pathIn0) begin
    tmpD0 = pathIn0;
    #25 delayed0 = tmpD0;
  end

  always @(pathIn0) begin
    tmpI0 = pathIn0;
    #15 inverted0 = ~tmpI0;
  end

  always @(pathIn1) begin
    tmpI1 = pathIn1;
    #15 inverted1 = ~tmpI1;
  end

  assign pathRes0 = modelSel ? inverted0 : delayed0;
  assign pathRes1 = inverted1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Runs one batch on both DUTs. Configuration inputs are scrambled right
  // after accept to show the latched values are used. latency is the number
  // of clock edges from the accept edge to the edge that raises done.
  task automatic applyStimulus(input logic [15:0] n, input logic [7:0] w,
                               output int latency, output int toggles);
    logic prev;
    @(negedge clk);
    start      = 1'b1;
    numTrials  = n;
    waitCycles = w;
    prev       = pathIn0;
    @(negedge clk);
    start      = 1'b0;
    numTrials  = 16'd3;
    waitCycles = 8'd9;
    latency    = 0;
    toggles    = 0;
    while (latency < 2000) begin
      if (pathIn0 !== prev) toggles++;
      prev = pathIn0;
      if (done0 === 1'b1) break;
      @(negedge clk);
      latency++;
    end
    checkOutput("done_seen", {31'd0, done0}, 32'd1);
    @(negedge clk);
    checkOutput("busy_after_done", {31'd0, busy0}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int tog;
    logic pathBefore;
    logic sawDone;

    rst_n      = 1'b0;
    start      = 1'b1;
    numTrials  = 16'd5;
    waitCycles = 8'd2;
    modelSel   = 1'b0;

    // Reset held with start asserted: everything stays quiet.
    repeat (3) @(negedge clk);
    checkOutput("rst_path_input", {31'd0, pathIn0}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy0}, 32'd0);
    checkOutput("rst_done", {31'd0, done0}, 32'd0);
    checkOutput("rst_err_count", {16'd0, err0}, 32'd0);
    checkOutput("rst_last_sample", {31'd0, last0}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_after_release", {31'd0, busy0}, 32'd0);

    // 10 trials, window 4 periods > 2.5: no errors, done at 10*10-4 = 96.
    applyStimulus(16'd10, 8'd3, lat, tog);
    checkOutput("w3_err", {16'd0, err0}, 32'd0);
    checkOutput("w3_latency", lat, 32'd96);
    checkOutput("w3_toggles", tog, 32'd10);

    // Window 1 period: always too early.
    applyStimulus(16'd10, 8'd0, lat, tog);
    checkOutput("w0_err", {16'd0, err0}, 32'd10);
    checkOutput("w0_latency", lat, 32'd66);

    // Window 2 periods < 2.5: still too early.
    applyStimulus(16'd10, 8'd1, lat, tog);
    checkOutput("w1_err", {16'd0, err0}, 32'd10);
    checkOutput("w1_latency", lat, 32'd76);

    // Zero trials with start held high: done right after accept, err cleared,
    // path untouched, then re-accepted after one idle cycle.
    pathBefore = pathIn0;
    @(negedge clk);
    start      = 1'b1;
    numTrials  = 16'd0;
    waitCycles = 8'd5;
    @(negedge clk);
    checkOutput("n0_done", {31'd0, done0}, 32'd1);
    checkOutput("n0_busy", {31'd0, busy0}, 32'd1);
    checkOutput("n0_err_cleared", {16'd0, err0}, 32'd0);
    checkOutput("n0_path_held", {31'd0, pathIn0}, {31'd0, pathBefore});
    @(negedge clk);
    checkOutput("n0_idle_gap_busy", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    checkOutput("n0_reaccept_busy", {31'd0, busy0}, 32'd1);
    checkOutput("n0_reaccept_done", {31'd0, done0}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    checkOutput("n0_final_idle", {31'd0, busy0}, 32'd0);

    // Window 3 periods > 2.5: settled every time.
    applyStimulus(16'd10, 8'd2, lat, tog);
    checkOutput("w2_err", {16'd0, err0}, 32'd0);
    checkOutput("w2_latency", lat, 32'd86);
    checkOutput("w2_toggles", tog, 32'd10);

    // Reset during WAIT of the third trial (after edge 22 of the batch).
    @(negedge clk);
    start      = 1'b1;
    numTrials  = 16'd10;
    waitCycles = 8'd3;
    @(negedge clk);
    start   = 1'b0;
    sawDone = 1'b0;
    repeat (22) begin
      @(negedge clk);
      sawDone = sawDone | done0;
    end
    checkOutput("mid_busy_before_rst", {31'd0, busy0}, 32'd1);
    checkOutput("mid_path_before_rst", {31'd0, pathIn0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {31'd0, busy0}, 32'd0);
    checkOutput("mid_rst_path_input", {31'd0, pathIn0}, 32'd0);
    checkOutput("mid_rst_err", {16'd0, err0}, 32'd0);
    checkOutput("mid_rst_last", {31'd0, last0}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      sawDone = sawDone | done0;
    end
    checkOutput("mid_rst_no_done", {31'd0, sawDone}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(16'd10, 8'd3, lat, tog);
    checkOutput("post_rst_err", {16'd0, err0}, 32'd0);
    checkOutput("post_rst_latency", lat, 32'd96);

    // Inverting 1.5-clock chain, window 3 periods: parity-matched instance
    // sees no errors, non-inverting instance mismatches every trial.
    modelSel = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(16'd5, 8'd2, lat, tog);
    checkOutput("inv_match_err", {16'd0, err1}, 32'd0);
    checkOutput("inv_mismatch_err", {16'd0, err0}, 32'd5);
    checkOutput("inv_latency", lat, 32'd41);
    checkOutput("inv_toggles", tog, 32'd5);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/spy_path_sampler.md
Name: spy_path_sampler

Overview:
- Launch/capture controller that sits directly upstream and downstream of a chained spy delay path (100 chained path stages).
- Drives the chain input with a registered launch transition and samples the chain output a programmable number of clock periods later.
- Compares each sample with the expected settled value and accumulates mismatches over a batch of trials.
- The mismatch count measures whether chain delay exceeds the programmed capture window (timing-fault / delay sensing).

Parameters:
- CNT_W, 16, width of num_trials, trial counter and err_count
- WAIT_W, 8, width of wait_cycles
- SETTLE_CYCLES, 4, idle cycles between trials so the chain settles before the next launch; must exceed worst-case chain delay in clocks; minimum 1
- INVERTING, 0, chain parity: 0 = output equals input when settled (even stage count), 1 = inverted

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a measurement batch; accepted only in IDLE
- num_trials  in  CNT_W  trials in the batch; latched on accept
- wait_cycles  in  WAIT_W  capture window; launch-to-capture = wait_cycles+1 clock periods; latched on accept
- path_input  out  1  registered launch signal to the chain input
- path_result  in  1  chain output; asynchronous to the launch timing by design
- busy  out  1  high from accept until the DONE cycle inclusive
- done  out  1  one-cycle pulse at batch end
- err_count  out  CNT_W  mismatches in the last batch; held until next accept
- last_sample  out  1  most recent captured path_result

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE; path_input, busy, done, err_count, last_sample, trial counter, wait counter all 0.
- States and cycle counts:
  - IDLE: start=1 accepts the batch. Latch num_trials and wait_cycles, clear err_count and the trial counter, set busy. Go to LAUNCH, or to DONE if num_trials==0.
  - LAUNCH (1 cycle): path_input toggles at the exiting edge (launch edge). expected <= new path_input ^ INVERTING. Load wait counter with wait_cycles.
  - WAIT (wait_cycles cycles; skipped if 0): decrement the counter, then go to CAPTURE.
  - CAPTURE (1 cycle): at the exiting edge, path_result is registered into last_sample. This capture edge is exactly wait_cycles+1 periods after the launch edge.
  - COMPARE (1 cycle): if last_sample != expected, err_count++. Trial counter increments. Go to DONE if the trial counter reaches num_trials, else to SETTLE.
  - SETTLE (SETTLE_CYCLES cycles): path_input held, then go to LAUNCH.
  - DONE (1 cycle): done=1, busy=1. Go to IDLE. busy drops the next cycle.
- Per-trial length = wait_cycles+3+SETTLE_CYCLES cycles. The done pulse occurs N*(wait_cycles+3+SETTLE_CYCLES)-SETTLE_CYCLES cycles after the accept edge; for N=0 it is 1 cycle after accept.
- path_input alternates polarity each trial and is never reset between batches except by rst_n.
- err_count cannot overflow because err_count ≤ num_trials; no saturation logic is needed.
- start while busy is ignored, with no queuing. start asserted in the DONE cycle is ignored; it is accepted the following cycle if still high.
- Changes to num_trials or wait_cycles while busy have no effect.
- rst_n asserted mid-batch: immediate return to reset values, with no done pulse.
- Only last_sample samples path_result. path_result goes to no other logic.

Decomposition:
- Shared package spy_pkg holds the state enum (IDLE, LAUNCH, WAIT, CAPTURE, COMPARE, SETTLE, DONE) and default width constants.
- No sub-module: a single FSM plus counters. The down-counter may be a small local always-block.

Test Plan:
- Reset: hold rst_n=0 with start=1 -> path_input=0, busy=0, done=0, err_count=0, last_sample=0. No activity until release.
- Bench chain model = path_input delayed 2.5 clk, INVERTING=0; start with num_trials=10, wait_cycles=3 -> err_count=0; done pulse exactly 96 cycles after accept; path_input toggles 10 times.
- Same model, wait_cycles=0, num_trials=10 -> every capture precedes arrival, err_count=10. Also check wait_cycles=1 -> err_count=10, and wait_cycles=2 -> err_count=0 (3 periods > 2.5).
- num_trials=0 -> done 1 cycle after accept, err_count=0, path_input unchanged. A start held high through the batch is re-accepted 1 cycle after done.
- Pulse rst_n low during WAIT of trial 3 -> all outputs return to 0 asynchronously, no done pulse. A new start after release runs a full batch correctly.
- INVERTING=1 with an inverting 1.5-clk model, wait_cycles=2, num_trials=5 -> err_count=0. Re-run with INVERTING=0 against the same model -> err_count=5.
